// File: rtl/instruction_fetch_pkg.sv
// core_pkg: shared fetch-stage constants, FSM state type and BR opcode helper.
// Imported by the fetch interface, queue and top.
package core_pkg;

    localparam int PC_STEP = 4;
    localparam int INST_W  = 32;

    localparam logic [31:0] BR_OPCODE = 32'hD600_0000;
    localparam logic [31:0] BR_MASK   = 32'hFFE0_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } fetch_state_e;

    function automatic logic is_br(input logic [31:0] ins);
        return (ins & BR_MASK) == BR_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction ROM port plus the valid/ready handshake to decode.
// master = fetch stage, slave = ROM/decode side.
interface instruction_fetch_if;
    import core_pkg::*;

    logic [31:0]       rom_address;
    logic              rom_chip_select;
    logic              rom_output_enable;
    logic [63:0]       rom_data;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [31:0]       inst_pc;

    modport master (
        output rom_address,
        output rom_chip_select,
        output rom_output_enable,
        input  rom_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  rom_address,
        input  rom_chip_select,
        input  rom_output_enable,
        output rom_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/instruction_fetch_queue.sv
// fetch_queue: circular buffer of {pc, inst}; flush wins over push/pop.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [W-1:0]               head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop  = pop_i & !empty_o;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= data_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, ROM control and instruction queue toward decode.
// Define FETCH_PERF_CNT_EN to add the fetch_count performance counter port.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_fetch_if.master  bus,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_count
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [31:0]       pc_q;
    logic [31:0]       pc_d;
    logic              pop;
    logic              fetch_en;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;
    logic [2*INST_W-1:0] q_head;
    logic              unused_rom_hi;

    assign pop      = bus.inst_valid & bus.inst_ready;
    assign fetch_en = (state_q != BOOT) & !redirect_valid
                    & ((int'(q_count) < QUEUE_DEPTH) | pop);

    assign bus.rom_address       = pc_q;
    assign bus.rom_chip_select   = fetch_en;
    assign bus.rom_output_enable = fetch_en;
    assign bus.inst_valid        = !q_empty;
    assign bus.inst_pc           = q_head[2*INST_W-1:INST_W];
    assign bus.inst              = q_head[INST_W-1:0];
    assign unused_rom_hi         = ^bus.rom_data[63:32];

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (2 * INST_W)
    ) u_queue (
        .clk     (clock),
        .rst     (reset),
        .push_i  (fetch_en),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  ({pc_q, bus.rom_data[INST_W-1:0]}),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count),
        .head_o  (q_head)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!redirect_valid && q_full && !pop) state_d = HOLD;
            end
            HOLD: begin
                if (pop || redirect_valid) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
        // redirect outranks the sequential increment
        if (redirect_valid) begin
            pc_d = {redirect_target[31:2], 2'b00};
        end else if (fetch_en) begin
            pc_d = pc_q + 32'(PC_STEP);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (fetch_en) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule
